// File: rtl/event_timestamper_if.sv
// Timestamp stream: valid/ready handshake carrying the FIFO head timestamp and its edge polarity.
interface event_timestamper_if #(
    parameter int TS_W = 32
);
    logic            ts_valid;
    logic            ts_ready;
    logic [TS_W-1:0] ts_data;
    logic            ts_edge;

    modport master (output ts_valid, ts_data, ts_edge, input ts_ready);
    modport slave  (input ts_valid, ts_data, ts_edge, output ts_ready);
endinterface

// File: rtl/event_timestamper.sv
// Free-running time counter that stamps trig edges into a small circular FIFO with sticky overflow.
// Optional macro TS_FALLING_EDGE_EN also captures falling edges (stored with edge polarity 0).
module event_timestamper #(
    parameter int TS_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   trig,
    event_timestamper_if.master    ts,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [TS_W-1:0] tm;
    logic            trig_q;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [TS_W-1:0] mem_ts [DEPTH];

    logic ev;
    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

`ifdef TS_FALLING_EDGE_EN
    logic mem_edge [DEPTH];
    assign ev = trig ^ trig_q;
`else
    assign ev = trig & ~trig_q;
`endif

    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);
    // A full FIFO still accepts an event when the head leaves on the same clock.
    assign pop   = ~empty & ts.ts_ready;
    assign push  = ev & (~full | pop);
    assign drop  = ev & full & ~pop;

    assign ts.ts_valid = ~empty;
    assign ts.ts_data  = empty ? '0 : mem_ts[rd_ptr];
`ifdef TS_FALLING_EDGE_EN
    assign ts.ts_edge  = ~empty & mem_edge[rd_ptr];
`else
    assign ts.ts_edge  = ~empty;
`endif

    // NOTE: reset is synchronous, so it lives inside the clocked branch; all state uses <=.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tm       <= '0;
            trig_q   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (en)   tm     <= tm + TS_W'(1);
            trig_q <= trig;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // NOTE: storage is not reset; entries are only visible through level, which is reset.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_ts[wr_ptr] <= tm;
`ifdef TS_FALLING_EDGE_EN
            mem_edge[wr_ptr] <= trig;
`endif
        end
    end
endmodule

// File: tb/tb_event_timestamper.sv
// Bench for event_timestamper: directed scenarios plus randomized traffic against a queue-based model.
module tb_event_timestamper;
    localparam int TS_W  = 8;
    localparam int DEPTH = 4;
    localparam int TSB_W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, trig = 1'b0;
    logic       en_b = 1'b0, trig_b = 1'b0;
    logic [2:0] level, level_b;
    logic       overflow, overflow_b;

    always #5 clk = ~clk;

    event_timestamper_if #(.TS_W(TS_W))  ts_a ();
    event_timestamper_if #(.TS_W(TSB_W)) ts_b ();

    event_timestamper #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .trig(trig),
        .ts(ts_a), .level(level), .overflow(overflow)
    );

    event_timestamper #(.TS_W(TSB_W), .DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .trig(trig_b),
        .ts(ts_b), .level(level_b), .overflow(overflow_b)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          pol;
        int unsigned ts;
    } entry_t;

    entry_t      mq[$];
    int unsigned m_tm = 0;
    bit          m_prev = 1'b0;
    bit          m_ovf = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a queue of {polarity, time}; events are judged against the queue size after any pop.
    task automatic model_clock();
        bit ev;
        if (!rst_n) begin
            mq.delete();
            m_tm   = 0;
            m_prev = 1'b0;
            m_ovf  = 1'b0;
        end else begin
`ifdef TS_FALLING_EDGE_EN
            ev = (trig != m_prev);
`else
            ev = trig && !m_prev;
`endif
            if (mq.size() > 0 && ts_a.ts_ready) void'(mq.pop_front());
            if (ev) begin
                if (mq.size() < DEPTH) mq.push_back('{pol: trig, ts: m_tm});
                else m_ovf = 1'b1;
            end
            if (en) m_tm = (m_tm + 1) % (1 << TS_W);
            m_prev = trig;
        end
    endtask

    task automatic compare_all();
        bit ne;
        ne = (mq.size() != 0);
        check("valid", ts_a.ts_valid, ne);
        check("data", ts_a.ts_data, ne ? mq[0].ts : 0);
        check("edge", ts_a.ts_edge, ne ? mq[0].pol : 1'b0);
        check("level", level, mq.size());
        check("overflow", overflow, m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cyc(input bit e, input bit t, input bit r);
        en = e;
        trig = t;
        ts_a.ts_ready = r;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        trig = 1'b0;
        ts_a.ts_ready = 1'b0;
        en_b = 1'b0;
        trig_b = 1'b0;
        ts_b.ts_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [TS_W-1:0] exp_seq [4];
        logic [TS_W-1:0] last;

        ts_a.ts_ready = 1'b0;
        ts_b.ts_ready = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_valid", ts_a.ts_valid, 1'b0);
        check("rst_level", level, 3'd0);

        // Basic capture at tm=5, then consume.
        for (int t = 0; t < 5; t++) cyc(1, 0, 0);
        cyc(1, 1, 0);
        check("cap_valid", ts_a.ts_valid, 1'b1);
        check("cap_data", ts_a.ts_data, 8'd5);
        check("cap_edge", ts_a.ts_edge, 1'b1);
        check("cap_level", level, 3'd1);
        cyc(1, 1, 1);
        check("cap_popped", ts_a.ts_valid, 1'b0);
        cyc(1, 0, 0);

        // Back-pressure and overflow.
        do_reset();
        for (int t = 0; t < 12; t++) cyc(1, (t >= 2 && t <= 10 && t % 2 == 0), 0);
`ifndef TS_FALLING_EDGE_EN
        check("ovf_level", level, 3'd4);
        check("ovf_flag", overflow, 1'b1);
        exp_seq = '{8'd2, 8'd4, 8'd6, 8'd8};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d", i), ts_a.ts_data, exp_seq[i]);
            cyc(1, 0, 1);
        end
        check("drain_empty", ts_a.ts_valid, 1'b0);
`endif

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int t = 0; t < 20; t++) cyc(1, (t >= 2 && t <= 8 && t % 2 == 0), 0);
        cyc(1, 1, 1);
`ifndef TS_FALLING_EDGE_EN
        check("pp_level", level, 3'd4);
        check("pp_noovf", overflow, 1'b0);
`endif
        last = '0;
        for (int i = 0; i < 8 && ts_a.ts_valid; i++) begin
            last = ts_a.ts_data;
            cyc(1, 0, 1);
        end
`ifndef TS_FALLING_EDGE_EN
        check("pp_last", last, 8'd20);
`endif

        // Counter wrap and hold on the 4-bit instance.
        do_reset();
        en_b = 1'b1;
        for (int i = 0; i < 17; i++) cyc(0, 0, 0);
        en_b = 1'b0;
        trig_b = 1'b1;
        cyc(0, 0, 0);
        check("wrap_valid", ts_b.ts_valid, 1'b1);
        check("wrap_data", ts_b.ts_data, 4'd1);
        trig_b = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        trig_b = 1'b1;
        cyc(0, 0, 0);
`ifdef TS_FALLING_EDGE_EN
        check("hold_level", level_b, 3'd3);
`else
        check("hold_level", level_b, 3'd2);
`endif
        ts_b.ts_ready = 1'b1;
        cyc(0, 0, 0);
        ts_b.ts_ready = 1'b0;
        check("hold_data", ts_b.ts_data, 4'd1);

        // Edge polarity option.
        do_reset();
        for (int t = 0; t < 10; t++) cyc(1, (t >= 3 && t < 7), 0);
        check("pol_data0", ts_a.ts_data, 8'd3);
        check("pol_edge0", ts_a.ts_edge, 1'b1);
`ifdef TS_FALLING_EDGE_EN
        check("pol_level", level, 3'd2);
        cyc(1, 0, 1);
        check("pol_data1", ts_a.ts_data, 8'd7);
        check("pol_edge1", ts_a.ts_edge, 1'b0);
`else
        check("pol_level", level, 3'd1);
`endif

        // Reset mid-operation, with trig held high through release.
        do_reset();
        for (int t = 0; t < 10; t++) cyc(1, (t % 2 == 1), 0);
        cyc(1, 0, 1);
`ifndef TS_FALLING_EDGE_EN
        check("mid_level", level, 3'd3);
        check("mid_ovf", overflow, 1'b1);
`endif
        rst_n = 1'b0;
        cyc(1, 1, 0);
        check("mr_valid", ts_a.ts_valid, 1'b0);
        check("mr_data", ts_a.ts_data, 8'd0);
        check("mr_edge", ts_a.ts_edge, 1'b0);
        check("mr_level", level, 3'd0);
        check("mr_ovf", overflow, 1'b0);
        rst_n = 1'b1;
        cyc(1, 1, 0);
        check("mr_cap_valid", ts_a.ts_valid, 1'b1);
        check("mr_cap_data", ts_a.ts_data, 8'd0);
        check("mr_cap_level", level, 3'd1);

        // Randomized traffic with varying back-pressure and occasional resets.
        do_reset();
        for (int blk = 0; blk < 15; blk++) begin
            int unsigned rdy_pct;
            rdy_pct = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                rst_n = ($urandom_range(0, 299) != 0);
                cyc(($urandom % 4) != 0,
                    (($urandom % 3) == 0) ? ~trig : trig,
                    $urandom_range(0, 99) < rdy_pct);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/event_timestamper.md
EVENT_TIMESTAMPER -- requirements
Module: event_timestamper

Interface
REQ-001 Parameter TS_W, default 32, width of the time counter and of the captured timestamp.
REQ-002 Parameter DEPTH, default 4, timestamp FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 en  input  1  counter enable; counter advances only while high.
REQ-006 trig  input  1  event input, sampled on posedge clk.
REQ-007 ts_valid  output  1  FIFO head holds a timestamp.
REQ-008 ts_ready  input  1  consumer accepts the head when ts_valid is also high.
REQ-009 ts_data  output  TS_W  head timestamp; 0 whenever ts_valid is low.
REQ-010 ts_edge  output  1  head edge polarity: 1 = rising, 0 = falling; 0 when ts_valid is low.
REQ-011 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-013 Time counter tm SHALL increment by 1 on each clock with en=1 and hold its value with en=0.
- Wraps from 2^TS_W-1 to 0 with no flag.
REQ-014 trig SHALL be registered once (trig_q); a rising event is trig=1 with trig_q=0.
REQ-015 A detected event SHALL push {edge, tm} into the FIFO on the same clock.
- tm is the counter value before that clock's increment.
- Events SHALL be captured regardless of en.
REQ-016 Pop SHALL occur on a clock with ts_valid=1 and ts_ready=1; the next entry appears on ts_data one clock later.
REQ-017 Push-to-ts_valid latency SHALL be 1 clock; there is no combinational path from trig to ts_valid.
REQ-018 ts_valid, ts_data and ts_edge SHALL hold stable while ts_valid=1 and ts_ready=0.
REQ-019 Simultaneous push and pop with level=DEPTH SHALL succeed: level stays DEPTH and no drop occurs.
REQ-020 Simultaneous push and pop with level=0 SHALL act as a push only; there is no bypass.
REQ-021 A push when level=DEPTH with no pop SHALL drop the event.
- overflow is set the next clock; FIFO contents are unchanged.
REQ-022 overflow SHALL clear only on reset.
REQ-023 level SHALL equal pushes minus pops since reset and never exceed DEPTH.
REQ-024 The FIFO is a circular buffer with read and write pointers that wrap at DEPTH.

Reset
REQ-025 While rst_n=0 at posedge clk, the following SHALL be 0 on the next clock: tm, trig_q, both pointers, level, ts_valid, ts_data, ts_edge and overflow.
REQ-026 Reset mid-operation SHALL discard all queued entries.
- A trig edge sampled during reset SHALL NOT be captured.
- trig_q loads 0, so trig=1 held through reset release produces a rising event on the first clock after reset.

Configuration
REQ-027 Macro TS_FALLING_EDGE_EN SHALL control falling-edge capture.
- Defined: falling events (trig=0 with trig_q=1) are also captured with edge=0, under the same push, drop and overflow rules.
- Undefined: only rising events are captured, ts_edge is always 1 when valid, and no falling-edge logic is present.

Verification
REQ-028 Basic capture: reset, en=1, trig rises at the clock where tm=5 -> one cycle later ts_valid=1, ts_data=5, ts_edge=1, level=1; ts_ready=1 -> ts_valid=0 on the following clock.
REQ-029 Back-pressure and overflow: DEPTH=4, ts_ready=0, five rising edges at tm=2,4,6,8,10 -> level=4, overflow=1.
- Draining then yields 2,4,6,8 in order.
REQ-030 Full with simultaneous push/pop: level=4 and ts_ready=1 held while an edge arrives at tm=20 -> no overflow, level stays 4, and 20 is the last entry drained.
REQ-031 Counter behaviour: TS_W=4, en=1 for 17 clocks from reset -> tm wraps to 0 and then reaches 1.
- en=0 for 3 clocks -> tm holds.
- An edge during en=0 captures the held value.
REQ-032 Falling-edge option: with TS_FALLING_EDGE_EN, trig 0->1 at tm=3 and 1->0 at tm=7 -> entries (3,1) then (7,0).
- Without the macro, only (3,1) is captured.
REQ-033 Reset mid-operation: level=3 and overflow=1, then rst_n=0 for 1 clock -> all outputs are 0 on the next clock and tm restarts at 0.
